// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wraps explicitly at DIV-1 and restarts on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= CW'(cnt + 1'b1);
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF sync, 3-sample majority vote, 8N1 framing.
// Build option: define UART_PARITY_EN for 8E1 framing with parity_err reporting.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV  = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned M    = OVERSAMPLE / 2;
  localparam int unsigned SCW  = $clog2(OVERSAMPLE);
  localparam int unsigned IDXW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0]  SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0]  SC_V0    = SCW'(M - 1);
  localparam logic [SCW-1:0]  SC_V1    = SCW'(M);
  localparam logic [SCW-1:0]  SC_V2    = SCW'(M + 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_START  = 3'(START);
  localparam logic [2:0] S_DATA   = 3'(DATA);
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(PARITY);
`endif
  localparam logic [2:0] S_STOP   = 3'(STOP);
  localparam logic [2:0] S_BREAK  = 3'(BREAK);

  logic            rx_meta, rx_s, rx_prev;
  logic [2:0]      state, state_nxt;
  logic [SCW-1:0]  sc;
  logic            v0, v1;
  logic [7:0]      shift, shift_nxt;
  logic [IDXW-1:0] idx, idx_nxt;
  logic [7:0]      rx_data_nxt;
  logic            valid_nxt, ferr_nxt;
  logic            tick;
  logic            clear_c;
  logic            vote_c;
  logic            vote_now_c;
`ifdef UART_PARITY_EN
  logic            perr, perr_nxt;
  logic            perr_pulse_nxt;
`endif

  // Two-flop synchronizer plus one-cycle history for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_c),
    .tick  (tick)
  );

  // Sample counter within a bit and the first two vote samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else if (clear_c) begin
      sc <= '0;
    end else if (tick) begin
      sc <= (sc == SC_LAST) ? '0 : SCW'(sc + 1'b1);
      if (sc == SC_V0) v0 <= rx_s;
      if (sc == SC_V1) v1 <= rx_s;
    end
  end

  assign vote_c     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign vote_now_c = tick && (sc == SC_V2);

  // Next-state, datapath and output-pulse decode.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    idx_nxt     = idx;
    rx_data_nxt = rx_data;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    clear_c     = 1'b0;
`ifdef UART_PARITY_EN
    perr_nxt       = perr;
    perr_pulse_nxt = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = S_START;
          clear_c   = 1'b1;
`ifdef UART_PARITY_EN
          perr_nxt  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (vote_now_c) begin
          if (vote_c) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end
        end
      end
      S_DATA: begin
        if (vote_now_c) begin
          shift_nxt[idx] = vote_c;
          if (idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = IDXW'(idx + 1'b1);
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (vote_now_c) begin
          perr_nxt  = (vote_c != ^shift);
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (vote_now_c) begin
          if (!vote_c) begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
`ifdef UART_PARITY_EN
          end else if (perr) begin
            perr_pulse_nxt = 1'b1;
            state_nxt      = S_IDLE;
`endif
          end else begin
            rx_data_nxt = shift;
            valid_nxt   = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift     <= '0;
      idx       <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift     <= shift_nxt;
      idx       <= idx_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

`ifdef UART_PARITY_EN
  // Sticky parity flag for the current frame and its output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      perr       <= perr_nxt;
      parity_err <= perr_pulse_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLK_HZ=1.6M, BAUD=10k (DIV=10, 160 clk/bit).
module tb_uart_rx_byte;

  localparam int BIT = 160;
`ifdef UART_PARITY_EN
  localparam int LAT = 1533 + BIT;
`else
  localparam int LAT = 1533;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  int cyc = 0;
  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, dbl_cnt = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_byte #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse collector, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
      valid_cyc = cyc;
    end
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr) || (parity_err && prev_perr))
      dbl_cnt++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_perr  = parity_err;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT);
  endtask

  // One frame; flip_par inverts the even-parity bit when parity is built in.
  task automatic send_byte(input logic [7:0] d, input logic stop_val, input logic flip_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ flip_par);
`else
    if (flip_par) rx = 1'b1;
`endif
    send_bit(stop_val);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clk(3);
    n_vec++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h exp 00", rx_data); end
    n_vec++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b exp 0", rx_valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
    n_vec++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b exp 0", parity_err); end
    n_vec++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    rst_n = 1'b1;
    wait_clk(50);
  endtask

  task automatic test_single;
    int v0, f0, start;
    v0 = valid_cnt; f0 = ferr_cnt;
    start = cyc;
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_clk(40);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d exp 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h exp a5", rx_data); end
    n_vec++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d exp 0", ferr_cnt - f0); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b exp 0", busy); end
    n_vec++;
    if ((valid_cyc - start < LAT - 12) || (valid_cyc - start > LAT + 12)) begin
      n_fail++; $display("FAIL single_latency: got %0d exp %0d+/-12", valid_cyc - start, LAT);
    end
    n_vec++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL single_pulse_width: got %0d long pulses exp 0", dbl_cnt); end
  endtask

  task automatic test_back_to_back;
    int v0, b0;
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
    v0 = valid_cnt; b0 = got_q.size();
    for (int i = 0; i < 3; i++) send_byte(exp_d[i], 1'b1, 1'b0);
    wait_clk(200);
    n_vec++; if (valid_cnt - v0 !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d exp 3", valid_cnt - v0); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (got_q.size() <= b0 + i) begin
        n_fail++; $display("FAIL b2b_data%0d: got none exp %h", i, exp_d[i]);
      end else if (got_q[b0 + i] !== exp_d[i]) begin
        n_fail++; $display("FAIL b2b_data%0d: got %h exp %h", i, got_q[b0 + i], exp_d[i]);
      end
    end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = valid_cnt;
    rx = 1'b0;
    wait_clk(40);
    rx = 1'b1;
    wait_clk(20);
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_mid: got %b exp 1", busy); end
    wait_clk(55);
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b exp 0", busy); end
    wait_clk(2000);
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d exp 0", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_data: got %h exp 3c", rx_data); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h5A, 1'b0, 1'b0);
    wait_clk(2000 - BIT);
    n_vec++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d exp 1", ferr_cnt - f0); end
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d exp 0", valid_cnt - v0); end
    n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b exp 1", busy); end
    n_vec++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL ferr_data: got %h exp 3c", rx_data); end
    rx = 1'b1;
    wait_clk(10);
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b exp 0", busy); end
    wait_clk(300);
  endtask

  task automatic test_reset_mid;
    int v0;
    logic [7:0] d;
    d = 8'hC3;
    v0 = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_clk(BIT / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_clk(1);
    n_vec++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h exp 00", rx_data); end
    n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(400);
    n_vec++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_nopulse: got %0d exp 0", valid_cnt - v0); end
    send_byte(8'h81, 1'b1, 1'b0);
    wait_clk(50);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d exp 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL rstmid_after: got %h exp 81", rx_data); end
    n_vec++; if (dbl_cnt !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d long pulses exp 0", dbl_cnt); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt; p0 = perr_cnt;
    send_byte(8'h07, 1'b1, 1'b0);
    wait_clk(50);
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL par_ok_count: got %0d exp 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data: got %h exp 07", rx_data); end
    n_vec++; if (perr_cnt - p0 !== 0) begin n_fail++; $display("FAIL par_ok_perr: got %0d exp 0", perr_cnt - p0); end
    send_byte(8'h07, 1'b1, 1'b1);
    wait_clk(50);
    n_vec++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d exp 1", perr_cnt - p0); end
    n_vec++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL par_bad_valid: got %0d exp 1", valid_cnt - v0); end
    n_vec++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h exp 07", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
